// File: rtl/sd_bd_fetch.sv
// sd_bd_fetch: reads buffer descriptors from BD memory, launches and retries SD block transfers, releases BDs
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   en                 fetch enable for new descriptors
//   free_bd            free-descriptor count from BD memory (pending when != BD_NUM)
//   re_s, ack_o_s      BD word read strobe / acknowledge
//   dat_out_s          BD word read data
//   a_cmp              BD release pulse
//   start_tx           transfer launch pulse to the sequencer
//   src_addr, blk_addr assembled source buffer and SD block address
//   tx_done, tx_err    transfer completion and failure qualifier
//   busy               descriptor in progress
//   err_drop           sticky: a BD was dropped after exhausting retries
module sd_bd_fetch #(
    parameter int DW        = 32,
    parameter int BD_W      = 8,
    parameter int BD_NUM    = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BD_W-1:0] free_bd,
    output logic            re_s,
    input  logic            ack_o_s,
    input  logic [DW-1:0]   dat_out_s,
    output logic            a_cmp,
    output logic            start_tx,
    output logic [31:0]     src_addr,
    output logic [31:0]     blk_addr,
    input  logic            tx_done,
    input  logic            tx_err,
    output logic            busy,
    output logic            err_drop
);
    localparam int WPB = (DW == 32) ? 2 : 4;
    localparam int RW  = $clog2(MAX_RETRY + 1);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, LAUNCH, XFER, CMPL, SETTLE} state_t;
    state_t        state;
    logic [2:0]    cnt;
    logic [2:0]    cnt_nx;
    logic [RW-1:0] retry;
    logic [31:0]   d32;
    assign d32    = 32'(dat_out_s);
    assign cnt_nx = cnt + 3'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            retry    <= '0;
            re_s     <= 1'b0;
            a_cmp    <= 1'b0;
            start_tx <= 1'b0;
            busy     <= 1'b0;
            err_drop <= 1'b0;
            src_addr <= '0;
            blk_addr <= '0;
        end else begin
            re_s     <= 1'b0;
            start_tx <= 1'b0;
            a_cmp    <= 1'b0;
            case (state)
                IDLE: if (en && free_bd != BD_W'(BD_NUM)) begin
                    state <= RD_REQ;
                    re_s  <= 1'b1;
                    busy  <= 1'b1;
                end
                RD_REQ: state <= RD_WAIT;
                RD_WAIT: if (ack_o_s) begin
                    // 32-bit: one word per address; 16-bit: cnt[1] picks the address, cnt[0] the half
                    if (DW == 32) begin
                        if (cnt[0]) blk_addr <= d32;
                        else src_addr <= d32;
                    end else if (cnt[1]) begin
                        if (cnt[0]) blk_addr[31:16] <= d32[15:0];
                        else blk_addr[15:0] <= d32[15:0];
                    end else begin
                        if (cnt[0]) src_addr[31:16] <= d32[15:0];
                        else src_addr[15:0] <= d32[15:0];
                    end
                    if (cnt_nx < 3'(WPB)) begin
                        cnt   <= cnt_nx;
                        state <= RD_REQ;
                        re_s  <= 1'b1;
                    end else begin
                        cnt      <= '0;
                        state    <= LAUNCH;
                        start_tx <= 1'b1;
                    end
                end
                LAUNCH: state <= XFER;
                XFER: if (tx_done) begin
                    if (!tx_err) begin
                        state <= CMPL;
                        a_cmp <= 1'b1;
                    end else if (retry < RW'(MAX_RETRY)) begin
                        retry    <= retry + 1'b1;
                        state    <= LAUNCH;
                        start_tx <= 1'b1;
                    end else begin
                        err_drop <= 1'b1;
                        state    <= CMPL;
                        a_cmp    <= 1'b1;
                    end
                end
                CMPL: begin
                    retry <= '0;
                    state <= SETTLE;
                end
                // extra cycle lets free_bd reflect the release before IDLE samples it
                SETTLE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_bd_fetch.sv
// tb_sd_bd_fetch: directed self-checking bench for sd_bd_fetch (DW=32 and DW=16 instances)
module tb_sd_bd_fetch;
    logic        clk = 0, rst = 1, en = 0, tx_done = 0, tx_err = 0;
    logic        ack32 = 0, ack16 = 0;
    logic [7:0]  free32 = 8'd4, free16 = 8'd4;
    logic [31:0] dat32 = 0;
    logic [15:0] dat16 = 0;
    logic        re32, cmp32, st32, busy32, drop32;
    logic        re16, cmp16, st16, busy16, drop16;
    logic [31:0] src32, blk32, src16, blk16;
    logic [31:0] mem32 [2];
    logic [15:0] mem16 [4];
    int checks = 0, failures = 0;
    int n_re32 = 0, n_st32 = 0, n_cmp32 = 0, n_re16 = 0, n_st16 = 0, n_cmp16 = 0;
    int cyc = 0, last_cmp = 0, gap = 0;
    logic gap_done = 1;
    int b_re, b_st, b_cmp, b_re16, b_st16, b_cmp16;

    always #5 clk = ~clk;

    sd_bd_fetch #(.DW(32)) u32 (
        .clk(clk), .rst(rst), .en(en), .free_bd(free32), .re_s(re32), .ack_o_s(ack32),
        .dat_out_s(dat32), .a_cmp(cmp32), .start_tx(st32), .src_addr(src32), .blk_addr(blk32),
        .tx_done(tx_done), .tx_err(tx_err), .busy(busy32), .err_drop(drop32)
    );

    sd_bd_fetch #(.DW(16)) u16 (
        .clk(clk), .rst(rst), .en(en), .free_bd(free16), .re_s(re16), .ack_o_s(ack16),
        .dat_out_s(dat16), .a_cmp(cmp16), .start_tx(st16), .src_addr(src16), .blk_addr(blk16),
        .tx_done(tx_done), .tx_err(tx_err), .busy(busy16), .err_drop(drop16)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re32) n_re32 <= n_re32 + 1;
        if (st32) n_st32 <= n_st32 + 1;
        if (cmp32) n_cmp32 <= n_cmp32 + 1;
        if (re16) n_re16 <= n_re16 + 1;
        if (st16) n_st16 <= n_st16 + 1;
        if (cmp16) n_cmp16 <= n_cmp16 + 1;
        if (cmp32) begin
            last_cmp <= cyc;
            gap_done <= 0;
        end
        if (re32 && !gap_done) begin
            gap      <= cyc - last_cmp;
            gap_done <= 1;
        end
    end

    // BD memory model: acknowledge one cycle after each read strobe
    initial begin : resp
        logic p32, p16;
        int w32, w16;
        p32 = 0; p16 = 0; w32 = 0; w16 = 0;
        forever begin
            @(posedge clk);
            #1;
            ack32 = p32;
            ack16 = p16;
            if (p32) begin
                dat32 = mem32[w32];
                w32 = (w32 + 1) % 2;
            end
            if (p16) begin
                dat16 = mem16[w16];
                w16 = (w16 + 1) % 4;
            end
            p32 = re32;
            p16 = re16;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int s);
        return s == 0 ? st32 : s == 1 ? cmp32 : s == 2 ? st16 : cmp16;
    endfunction

    task automatic wait_for(input string tag, input int s);
        logic hit;
        hit = 0;
        for (int i = 0; i < 60; i++) begin
            if (sig(s)) begin
                hit = 1;
                break;
            end
            tick();
        end
        chk(tag, {31'd0, hit}, 32'd1);
    endtask

    task automatic finish_tx(input logic e);
        tick();
        tx_done = 1;
        tx_err  = e;
        tick();
        tx_done = 0;
        tx_err  = 0;
    endtask

    task automatic snap();
        b_re = n_re32; b_st = n_st32; b_cmp = n_cmp32;
        b_re16 = n_re16; b_st16 = n_st16; b_cmp16 = n_cmp16;
    endtask

    initial begin
        mem32[0] = 32'h0000_1000; mem32[1] = 32'h0000_0020;
        mem16[0] = 16'h1000; mem16[1] = 16'h0000; mem16[2] = 16'h0020; mem16[3] = 16'h0000;
        #1;
        chk("rst_ctl32", {27'd0, re32, cmp32, st32, busy32, drop32}, 0);
        chk("rst_addr32", src32 | blk32, 0);
        chk("rst_ctl16", {27'd0, re16, cmp16, st16, busy16, drop16}, 0);
        tick(3);
        rst = 0;
        tick(2);
        // single BD, 32-bit words
        snap();
        en = 1;
        free32 = 8'd3;
        wait_for("t1_start", 0);
        chk("t1_src", src32, 32'h0000_1000);
        chk("t1_blk", blk32, 32'h0000_0020);
        chk("t1_busy", {31'd0, busy32}, 1);
        chk("t1_re_cnt", n_re32 - b_re, 2);
        tx_done = 1;
        tick();
        tx_done = 0;
        tick(3);
        chk("t1_done_in_launch_ignored", n_cmp32 - b_cmp, 0);
        finish_tx(0);
        wait_for("t1_cmp", 1);
        free32 = 8'd4;
        tick(6);
        chk("t1_st_cnt", n_st32 - b_st, 1);
        chk("t1_cmp_cnt", n_cmp32 - b_cmp, 1);
        chk("t1_re_total", n_re32 - b_re, 2);
        chk("t1_idle_busy", {31'd0, busy32}, 0);
        // single BD, 16-bit words
        snap();
        free16 = 8'd3;
        wait_for("t2_start", 2);
        chk("t2_src", src16, 32'h0000_1000);
        chk("t2_blk", blk16, 32'h0000_0020);
        chk("t2_re_cnt", n_re16 - b_re16, 4);
        finish_tx(0);
        wait_for("t2_cmp", 3);
        free16 = 8'd4;
        tick(6);
        chk("t2_st_cnt", n_st16 - b_st16, 1);
        chk("t2_cmp_cnt", n_cmp16 - b_cmp16, 1);
        chk("t2_busy", {31'd0, busy16}, 0);
        // two failures then success
        snap();
        free32 = 8'd3;
        for (int k = 0; k < 3; k++) begin
            wait_for("t3_start", 0);
            finish_tx(k < 2);
        end
        wait_for("t3_cmp", 1);
        free32 = 8'd4;
        tick(6);
        chk("t3_st_cnt", n_st32 - b_st, 3);
        chk("t3_cmp_cnt", n_cmp32 - b_cmp, 1);
        chk("t3_drop", {31'd0, drop32}, 0);
        // four failures: BD dropped
        snap();
        free32 = 8'd3;
        for (int k = 0; k < 4; k++) begin
            wait_for("t4_start", 0);
            finish_tx(1);
        end
        wait_for("t4_cmp", 1);
        free32 = 8'd4;
        tick(6);
        chk("t4_st_cnt", n_st32 - b_st, 4);
        chk("t4_cmp_cnt", n_cmp32 - b_cmp, 1);
        chk("t4_drop", {31'd0, drop32}, 1);
        // two pending BDs back to back, en dropped during the second
        snap();
        free32 = 8'd2;
        wait_for("t5_start_a", 0);
        finish_tx(0);
        wait_for("t5_cmp_a", 1);
        free32 = 8'd3;
        wait_for("t5_start_b", 0);
        en = 0;
        chk("t5_gap", gap, 3);
        finish_tx(0);
        wait_for("t5_cmp_b", 1);
        tick(10);
        chk("t5_re_cnt", n_re32 - b_re, 4);
        chk("t5_st_cnt", n_st32 - b_st, 2);
        chk("t5_cmp_cnt", n_cmp32 - b_cmp, 2);
        chk("t5_en_off_busy", {31'd0, busy32}, 0);
        chk("t5_drop_sticky", {31'd0, drop32}, 1);
        // reset while in XFER
        snap();
        en = 1;
        wait_for("t6_start", 0);
        tick();
        #2;
        rst = 1;
        #1;
        chk("t6_rst_ctl", {27'd0, re32, cmp32, st32, busy32, drop32}, 0);
        chk("t6_rst_src", src32, 0);
        chk("t6_rst_blk", blk32, 0);
        free32 = 8'd4;
        tick(2);
        rst = 0;
        tick(10);
        chk("t6_no_cmp", n_cmp32 - b_cmp, 0);
        chk("t6_re_after", n_re32 - b_re, 2);
        chk("t6_idle_busy", {31'd0, busy32}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
